// File: rtl/playback_controller_pkg.sv
// Shared definitions for the playback controller and song_reader: FSM state
// encodings and the default song-select width.
package playback_controller_pkg;

  localparam int STATE_W        = 2;
  localparam int SONG_SEL_W_DEF = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_PAUSED       = 2'b00;
  localparam logic [1:0] ST_PLAYING      = 2'b01;
  localparam logic [1:0] ST_SWITCH_PAUSE = 2'b10;
  localparam logic [1:0] ST_SWITCH_PLAY  = 2'b11;

  // Both SWITCH_* encodings share the MSB, so it alone marks a song change.
  function automatic logic is_switch(input state_t st);
    return st[1];
  endfunction

endpackage

// File: rtl/playback_controller_if.sv
// Button/done inputs and player control outputs of the playback controller.
interface playback_controller_if #(
  parameter int SEL_WIDTH = 2
);
  logic                 play_btn;
  logic                 next_btn;
  logic                 prev_btn;
  logic                 ff_btn;
  logic                 rw_btn;
  logic                 song_done;
  logic                 play;
  logic [SEL_WIDTH-1:0] song;
  logic                 reset_player;
  logic                 ff;
  logic                 rewind;

  modport master (
    output play_btn, next_btn, prev_btn, ff_btn, rw_btn, song_done,
    input  play, song, reset_player, ff, rewind
  );

  modport slave (
    input  play_btn, next_btn, prev_btn, ff_btn, rw_btn, song_done,
    output play, song, reset_player, ff, rewind
  );
endinterface

// File: rtl/playback_controller_song_index_step.sv
// Modulo-NUM_SONGS increment/decrement of the song index, plus a flag that the
// current song is the last one in the given playback direction.
module song_index_step #(
  parameter int NUM_SONGS = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [SEL_WIDTH-1:0] i_song,
  input  logic                 i_reverse,
  output logic [SEL_WIDTH-1:0] o_inc,
  output logic [SEL_WIDTH-1:0] o_dec,
  output logic                 o_last
);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_SONGS - 1);

  logic w_at_first;
  logic w_at_last;

  assign w_at_first = (i_song == '0);
  assign w_at_last  = (i_song == LAST_IDX);

  assign o_inc  = w_at_last  ? '0       : i_song + SEL_WIDTH'(1);
  assign o_dec  = w_at_first ? LAST_IDX : i_song - SEL_WIDTH'(1);
  assign o_last = i_reverse  ? w_at_first : w_at_last;
endmodule

// File: rtl/playback_controller.sv
// Playback sequencer: buttons and song_done drive play/song/ff/rewind controls.
// Build option PLAYLIST_LOOP_EN: automatic advance wraps past the last song.
module playback_controller
  import playback_controller_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int SEL_WIDTH = SONG_SEL_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  playback_controller_if.slave bus
);
`ifdef PLAYLIST_LOOP_EN
  localparam bit STOP_AT_END = 1'b0;
`else
  localparam bit STOP_AT_END = 1'b1;
`endif

  state_t               r_state;
  logic [SEL_WIDTH-1:0] r_song;
  logic                 r_play;
  logic                 r_reset_player;
  logic                 r_ff;
  logic                 r_rewind;

  state_t               w_state_next;
  logic [SEL_WIDTH-1:0] w_song_next;
  logic                 w_mode_clear;
  logic [SEL_WIDTH-1:0] w_inc;
  logic [SEL_WIDTH-1:0] w_dec;
  logic                 w_last;

  song_index_step #(
    .NUM_SONGS (NUM_SONGS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_step (
    .i_song    (r_song),
    .i_reverse (r_rewind),
    .o_inc     (w_inc),
    .o_dec     (w_dec),
    .o_last    (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    w_song_next  = r_song;
    w_mode_clear = 1'b0;
    case (r_state)
      ST_PAUSED: begin
        if (bus.next_btn) begin
          w_song_next  = w_inc;
          w_state_next = ST_SWITCH_PAUSE;
        end else if (bus.prev_btn) begin
          w_song_next  = w_dec;
          w_state_next = ST_SWITCH_PAUSE;
        end else if (bus.play_btn) begin
          w_state_next = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (bus.song_done) begin
          // End of playlist in the playing direction stops on song 0.
          if (STOP_AT_END && w_last) begin
            w_song_next  = '0;
            w_state_next = ST_SWITCH_PAUSE;
            w_mode_clear = 1'b1;
          end else begin
            w_song_next  = r_rewind ? w_dec : w_inc;
            w_state_next = ST_SWITCH_PLAY;
          end
        end else if (bus.next_btn) begin
          w_song_next  = w_inc;
          w_state_next = ST_SWITCH_PLAY;
        end else if (bus.prev_btn) begin
          w_song_next  = w_dec;
          w_state_next = ST_SWITCH_PLAY;
        end else if (bus.play_btn) begin
          w_state_next = ST_PAUSED;
        end
      end
      ST_SWITCH_PAUSE: w_state_next = ST_PAUSED;
      default:         w_state_next = ST_PLAYING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_PAUSED;
      r_song         <= '0;
      r_play         <= 1'b0;
      r_reset_player <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_song         <= w_song_next;
      r_play         <= (w_state_next == ST_PLAYING);
      r_reset_player <= is_switch(w_state_next);
    end
  end

  // Mode register runs in every state, SWITCH_* included.
  always_ff @(posedge clk) begin
    if (reset || w_mode_clear || (bus.ff_btn && bus.rw_btn)) begin
      r_ff     <= 1'b0;
      r_rewind <= 1'b0;
    end else if (bus.ff_btn) begin
      r_ff     <= ~r_ff;
      r_rewind <= 1'b0;
    end else if (bus.rw_btn) begin
      r_ff     <= 1'b0;
      r_rewind <= ~r_rewind;
    end
  end

  assign bus.play         = r_play;
  assign bus.song         = r_song;
  assign bus.reset_player = r_reset_player;
  assign bus.ff           = r_ff;
  assign bus.rewind       = r_rewind;
endmodule
